// File: rtl/multi_digit_display.sv
// multi_digit_display
//   N-digit multiplexed 7-segment driver. A binary value captured on LOAD is converted
//   to BCD by a sequential shift-add-3 (double dabble) engine, then the digits are
//   time-multiplexed onto one shared segment bus. Supports signed/unsigned input,
//   minus sign, leading-zero blanking, overflow saturation and a BUSY handshake.
//
// Ports
//   CLK           in   1            system clock, rising edge
//   RESET_N       in   1            asynchronous active-low reset
//   DATA_IN       in   DATA_WIDTH   value to display
//   LOAD          in   1            capture DATA_IN this cycle (ignored while BUSY)
//   SEGMENTS      out  7            {a,b,c,d,e,f,g}, registered
//   DIGIT_SELECT  out  NUM_DIGITS   one-hot digit enable, bit0 = ones digit, registered
//   BUSY          out  1            conversion in progress
//   OVERFLOW      out  1            displayed value is saturated
module multi_digit_display #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned DATA_WIDTH     = 12,
    parameter int unsigned REFRESH_CYCLES = 100_000,
    parameter int unsigned SIGNED_MODE    = 1,
    parameter int unsigned SEG_ACTIVE_LOW = 0,
    parameter int unsigned BLANK_LEADING  = 1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  LOAD,
    output logic [6:0]            SEGMENTS,
    output logic [NUM_DIGITS-1:0] DIGIT_SELECT,
    output logic                  BUSY,
    output logic                  OVERFLOW
);

    // Number of BCD nibbles needed to hold any DATA_WIDTH-bit magnitude.
    localparam int unsigned NB    = DATA_WIDTH * 3 / 10 + 1;
    localparam int unsigned BW    = NB * 4;
    localparam int unsigned SW    = BW + DATA_WIDTH;
    // Digits usable for magnitude; the top digit carries the sign in signed mode.
    localparam int unsigned AVAIL = (SIGNED_MODE != 0) ? NUM_DIGITS - 1 : NUM_DIGITS;
    localparam int unsigned EXT_N = (NB > NUM_DIGITS) ? NB : NUM_DIGITS;
    localparam int unsigned CW    = $clog2(DATA_WIDTH);
    localparam int unsigned SCW   = $clog2(REFRESH_CYCLES);
    localparam int unsigned IW    = $clog2(NUM_DIGITS);

    localparam logic [6:0] GLYPH_MINUS = 7'b0000001;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
    localparam logic [6:0] GLYPH_ZERO  = 7'b1111110;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StCommit
    } state_e;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1111110;
            4'd1:    g = 7'b0110000;
            4'd2:    g = 7'b1101101;
            4'd3:    g = 7'b1111001;
            4'd4:    g = 7'b0110011;
            4'd5:    g = 7'b1011011;
            4'd6:    g = 7'b1011111;
            4'd7:    g = 7'b1110000;
            4'd8:    g = 7'b1111111;
            4'd9:    g = 7'b1110011;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    // Builds the glyph for every digit from a BCD result, sign and overflow flag.
    // Digits are walked from the top down so blanking stops at the first nonzero digit.
    function automatic logic [NUM_DIGITS*7-1:0] build_glyphs(
        input logic [BW-1:0] bcd,
        input logic          neg,
        input logic          ovf
    );
        logic [NUM_DIGITS*7-1:0] g;
        logic [EXT_N*4-1:0]      ext;
        logic [3:0]              dig;
        logic                    seen;
        g              = '0;
        ext            = '0;
        ext[BW-1:0]    = bcd;
        seen           = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if ((SIGNED_MODE != 0) && (i == NUM_DIGITS - 1)) begin
                g[i*7+:7] = neg ? GLYPH_MINUS : GLYPH_BLANK;
            end else begin
                dig = ovf ? 4'd9 : ext[i*4+:4];
                if ((dig != 4'd0) || (i == 0) || ovf || (BLANK_LEADING == 0)) begin
                    seen = 1'b1;
                end
                g[i*7+:7] = seen ? digit_glyph(dig) : GLYPH_BLANK;
            end
        end
        return g;
    endfunction

    function automatic logic [6:0] seg_polarity(input logic [6:0] g);
        return (SEG_ACTIVE_LOW != 0) ? ~g : g;
    endfunction

    localparam logic [NUM_DIGITS*7-1:0] RESET_BUF = build_glyphs('0, 1'b0, 1'b0);
    localparam logic [6:0]              SEG_RESET = seg_polarity(GLYPH_ZERO);

    state_e                  state_q;
    logic [SW-1:0]           shift_q;
    logic [CW-1:0]           bit_cnt_q;
    logic                    neg_pend_q;
    logic [NUM_DIGITS*7-1:0] glyph_buf_q;
    logic [SCW-1:0]          scan_cnt_q;
    logic [IW-1:0]           idx_q;

    logic [SW-1:0]           shift_adj;
    logic [SW-1:0]           shift_next;
    logic [BW-1:0]           bcd_res;
    logic                    ovf_res;
    logic [NUM_DIGITS*7-1:0] commit_glyphs;
    logic                    neg_in;
    logic [DATA_WIDTH-1:0]   mag_in;
    logic [IW-1:0]           idx_nxt;
    logic [6:0]              glyph_nxt;

    // Input magnitude; the most negative value wraps to 2^(DATA_WIDTH-1) as unsigned.
    always_comb begin
        neg_in = (SIGNED_MODE != 0) && DATA_IN[DATA_WIDTH-1];
        mag_in = neg_in ? (~DATA_IN + 1'b1) : DATA_IN;
    end

    // One double-dabble step: correct nibbles >= 5, then shift {bcd, bin} left.
    always_comb begin
        shift_adj = shift_q;
        for (int i = 0; i < NB; i++) begin
            if (shift_adj[DATA_WIDTH+i*4+:4] >= 4'd5) begin
                shift_adj[DATA_WIDTH+i*4+:4] = shift_adj[DATA_WIDTH+i*4+:4] + 4'd3;
            end
        end
        shift_next = shift_adj << 1;
    end

    // Overflow when any BCD nibble beyond the available digits is nonzero.
    always_comb begin
        bcd_res = shift_q[SW-1:DATA_WIDTH];
        ovf_res = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if ((i >= int'(AVAIL)) && (bcd_res[i*4+:4] != 4'd0)) begin
                ovf_res = 1'b1;
            end
        end
        commit_glyphs = build_glyphs(bcd_res, neg_pend_q, ovf_res);
    end

    // Conversion FSM with registered BUSY/OVERFLOW.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            neg_pend_q  <= 1'b0;
            glyph_buf_q <= RESET_BUF;
            BUSY        <= 1'b0;
            OVERFLOW    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (LOAD) begin
                        shift_q    <= {{BW{1'b0}}, mag_in};
                        neg_pend_q <= neg_in;
                        bit_cnt_q  <= '0;
                        BUSY       <= 1'b1;
                        state_q    <= StConvert;
                    end
                end
                StConvert: begin
                    shift_q   <= shift_next;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                        state_q <= StCommit;
                    end
                end
                StCommit: begin
                    glyph_buf_q <= commit_glyphs;
                    OVERFLOW    <= ovf_res;
                    BUSY        <= 1'b0;
                    state_q     <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        idx_nxt   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        glyph_nxt = glyph_buf_q[idx_nxt*7+:7];
    end

    // Refresh scan; outputs only change at slot boundaries, independent of the FSM.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            scan_cnt_q   <= '0;
            idx_q        <= '0;
            DIGIT_SELECT <= NUM_DIGITS'(1);
            SEGMENTS     <= SEG_RESET;
        end else begin
            if (scan_cnt_q == SCW'(REFRESH_CYCLES - 1)) begin
                scan_cnt_q   <= '0;
                idx_q        <= idx_nxt;
                DIGIT_SELECT <= NUM_DIGITS'(1) << idx_nxt;
                SEGMENTS     <= seg_polarity(glyph_nxt);
            end else begin
                scan_cnt_q <= scan_cnt_q + SCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_multi_digit_display.sv
// Testbench for multi_digit_display: three instances (signed, unsigned, signed with
// active-low segments) share clock and reset; table-driven loads plus hand sequences.
module tb_multi_digit_display;

    localparam logic [6:0] G0 = 7'b1111110;
    localparam logic [6:0] G1 = 7'b0110000;
    localparam logic [6:0] G2 = 7'b1101101;
    localparam logic [6:0] G3 = 7'b1111001;
    localparam logic [6:0] G4 = 7'b0110011;
    localparam logic [6:0] G5 = 7'b1011011;
    localparam logic [6:0] G7 = 7'b1110000;
    localparam logic [6:0] G8 = 7'b1111111;
    localparam logic [6:0] G9 = 7'b1110011;
    localparam logic [6:0] GM = 7'b0000001;
    localparam logic [6:0] GB = 7'b0000000;

    logic        clk;
    logic        rst_n;
    logic [11:0] data  [3];
    logic        load  [3];
    logic [6:0]  seg   [3];
    logic [3:0]  sel   [3];
    logic        busy  [3];
    logic        ovf   [3];
    logic [6:0]  frame [4];

    int total;
    int bad;

    multi_digit_display #(.NUM_DIGITS(4), .DATA_WIDTH(12), .REFRESH_CYCLES(4),
        .SIGNED_MODE(1), .SEG_ACTIVE_LOW(0), .BLANK_LEADING(1)) u_signed (
        .CLK(clk), .RESET_N(rst_n), .DATA_IN(data[0]), .LOAD(load[0]),
        .SEGMENTS(seg[0]), .DIGIT_SELECT(sel[0]), .BUSY(busy[0]), .OVERFLOW(ovf[0]));

    multi_digit_display #(.NUM_DIGITS(4), .DATA_WIDTH(12), .REFRESH_CYCLES(4),
        .SIGNED_MODE(0), .SEG_ACTIVE_LOW(0), .BLANK_LEADING(1)) u_unsigned (
        .CLK(clk), .RESET_N(rst_n), .DATA_IN(data[1]), .LOAD(load[1]),
        .SEGMENTS(seg[1]), .DIGIT_SELECT(sel[1]), .BUSY(busy[1]), .OVERFLOW(ovf[1]));

    multi_digit_display #(.NUM_DIGITS(4), .DATA_WIDTH(12), .REFRESH_CYCLES(4),
        .SIGNED_MODE(1), .SEG_ACTIVE_LOW(1), .BLANK_LEADING(1)) u_actlow (
        .CLK(clk), .RESET_N(rst_n), .DATA_IN(data[2]), .LOAD(load[2]),
        .SEGMENTS(seg[2]), .DIGIT_SELECT(sel[2]), .BUSY(busy[2]), .OVERFLOW(ovf[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          n;
        logic [11:0] d;
        logic [6:0]  e3;
        logic [6:0]  e2;
        logic [6:0]  e1;
        logic [6:0]  e0;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input int n, input logic [11:0] v);
        @(negedge clk);
        data[n] = v;
        load[n] = 1'b1;
        @(negedge clk);
        load[n] = 1'b0;
    endtask

    // Counts negedges with BUSY high starting at the current one; bounded.
    task automatic wait_idle(input int n, output int cycles);
        cycles = 0;
        while (busy[n] && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    // Skips one slot so the display reflects the latest buffer, then samples one frame.
    task automatic capture(input int n);
        for (int d = 0; d < 4; d++) frame[d] = 7'bx;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            for (int d = 0; d < 4; d++) begin
                if (sel[n] == (4'b0001 << d)) frame[d] = seg[n];
            end
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input string name, input int n, input logic [6:0] e3,
                               input logic [6:0] e2, input logic [6:0] e1,
                               input logic [6:0] e0);
        logic [6:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        capture(n);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("%s digit%0d", name, d), {25'd0, frame[d]},
                  {25'd0, (n == 2) ? ~e[d] : e[d]});
        end
    endtask

    initial begin
        int         cyc;
        logic [3:0] one;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data[i] = '0;
            load[i] = 1'b0;
        end

        vecs[0]  = '{0, 12'd987, GB, G9, G8, G7, 1'b0};
        vecs[1]  = '{0, 12'hFF6, GM, GB, G1, G0, 1'b0};
        vecs[2]  = '{0, 12'd1,   GB, GB, GB, G1, 1'b0};
        vecs[3]  = '{0, 12'd999, GB, G9, G9, G9, 1'b0};
        vecs[4]  = '{0, 12'd1000, GB, G9, G9, G9, 1'b1};
        vecs[5]  = '{0, 12'hC19, GM, G9, G9, G9, 1'b0};
        vecs[6]  = '{0, 12'h800, GM, G9, G9, G9, 1'b1};
        vecs[7]  = '{1, 12'hFFF, G4, G0, G9, G5, 1'b0};
        vecs[8]  = '{1, 12'd0,   GB, GB, GB, G0, 1'b0};
        vecs[9]  = '{1, 12'd1000, G1, G0, G0, G0, 1'b0};
        vecs[10] = '{2, 12'd987, GB, G9, G8, G7, 1'b0};
        vecs[11] = '{2, 12'hFF6, GM, GB, G1, G0, 1'b0};

        // Reset release and free-running scan.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            one = 4'b0001 << (k / 4);
            check($sformatf("scan sel k=%0d", k), {28'd0, sel[0]}, {28'd0, one});
            check($sformatf("scan seg k=%0d", k), {25'd0, seg[0]},
                  {25'd0, (k < 4) ? G0 : GB});
            if (k < 4) check("scan actlow seg", {25'd0, seg[2]}, {25'd0, ~G0});
            @(negedge clk);
        end
        check("reset busy", {31'd0, busy[0]}, 32'd0);
        check("reset ovf", {31'd0, ovf[0]}, 32'd0);
        check_frame("reset frame unsigned", 1, GB, GB, GB, G0);

        // Table-driven conversions.
        for (int v = 0; v < 12; v++) begin
            do_load(vecs[v].n, vecs[v].d);
            wait_idle(vecs[v].n, cyc);
            check($sformatf("vec%0d busy cycles", v), cyc, 32'd13);
            check_frame($sformatf("vec%0d", v), vecs[v].n, vecs[v].e3, vecs[v].e2,
                        vecs[v].e1, vecs[v].e0);
            check($sformatf("vec%0d ovf", v), {31'd0, ovf[vecs[v].n]}, {31'd0, vecs[v].ovf});
        end

        // LOAD while BUSY is dropped.
        do_load(1, 12'd123);
        @(negedge clk);
        data[1] = 12'd456;
        load[1] = 1'b1;
        @(negedge clk);
        load[1] = 1'b0;
        wait_idle(1, cyc);
        check("drop busy remaining", cyc, 32'd11);
        check_frame("drop frame", 1, GB, G1, G2, G3);

        // LOAD on the first non-BUSY cycle is accepted.
        do_load(1, 12'd321);
        wait_idle(1, cyc);
        check("first idle wait", cyc, 32'd13);
        data[1] = 12'd77;
        load[1] = 1'b1;
        @(negedge clk);
        load[1] = 1'b0;
        check("first idle accept busy", {31'd0, busy[1]}, 32'd1);
        wait_idle(1, cyc);
        check("first idle busy cycles", cyc, 32'd13);
        check_frame("first idle frame", 1, GB, GB, G7, G7);

        // LOAD during the COMMIT cycle is dropped.
        do_load(0, 12'd5);
        repeat (12) @(negedge clk);
        check("commit cycle busy", {31'd0, busy[0]}, 32'd1);
        data[0] = 12'd8;
        load[0] = 1'b1;
        @(negedge clk);
        load[0] = 1'b0;
        check("commit drop busy0", {31'd0, busy[0]}, 32'd0);
        @(negedge clk);
        check("commit drop busy1", {31'd0, busy[0]}, 32'd0);
        check_frame("commit drop frame", 0, GB, GB, GB, G5);

        // Reset mid-conversion.
        do_load(0, 12'h800);
        wait_idle(0, cyc);
        check("pre-reset ovf", {31'd0, ovf[0]}, 32'd1);
        do_load(0, 12'd42);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async reset busy", {31'd0, busy[0]}, 32'd0);
        check("async reset ovf", {31'd0, ovf[0]}, 32'd0);
        check("async reset sel", {28'd0, sel[0]}, 32'd1);
        check("async reset seg", {25'd0, seg[0]}, {25'd0, G0});
        check("async reset actlow seg", {25'd0, seg[2]}, {25'd0, ~G0});
        check("async reset actlow sel", {28'd0, sel[2]}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post reset busy", {31'd0, busy[0]}, 32'd0);
        check_frame("post reset frame", 0, GB, GB, GB, G0);
        check("post reset ovf", {31'd0, ovf[0]}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
